// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive capture FSM feeding a show-ahead byte FIFO with sticky overrun.
module uart_rx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_busy,
  input  logic [7:0]        rx_data,
  output logic              clr_buffer,
  input  logic              rd_en,
  output logic [7:0]        dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr
);

  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_next;
  logic                push;
  logic                push_ok, pop_ok, ovr_set;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [7:0]          mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clr_buffer <= 1'b0;
    end else begin
      state      <= state_next;
      clr_buffer <= (state_next == CLEAR);
    end
  end

  // A push happens only on the busy->idle transition seen from BUSY.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE:    if (rx_busy) state_next = BUSY;
      BUSY:    if (!rx_busy) begin
                 push       = 1'b1;
                 state_next = CLEAR;
               end
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop_ok  = rd_en && !empty;
  // When full, a push is accepted only if a pop frees the slot in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign ovr_set = push && full && !pop_ok;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed self-checking bench for uart_rx_buffer.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_buffer;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty, full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .rx_busy(rx_busy), .rx_data(rx_data),
    .clr_buffer(clr_buffer), .rd_en(rd_en), .dout(dout), .empty(empty),
    .full(full), .count(count), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; rx_busy = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Frame with optional pop and ovr_clr aligned to the push edge; returns at a negedge with FSM in IDLE.
  task automatic send_frame(input logic [7:0] b, input int busy_cycles, input logic pop, input logic oc);
    @(negedge clk); rx_busy = 1'b1;
    repeat (busy_cycles) @(negedge clk);
    rx_busy = 1'b0; rx_data = b; rd_en = pop; ovr_clr = oc;
    @(negedge clk); rd_en = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (clr_buffer !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b expected 0", clr_buffer); end
  endtask

  task automatic test_single_frame();
    do_reset();
    @(negedge clk); rx_busy = 1'b1;
    repeat (10) @(negedge clk);
    rx_busy = 1'b0; rx_data = 8'hA5;
    n_checks++; if (count !== 5'd0 || clr_buffer !== 1'b0) begin n_fail++; $display("FAIL single_pre: got count %0d clr %b expected 0 0", count, clr_buffer); end
    @(negedge clk);
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", empty); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout: got %h expected a5", dout); end
    n_checks++; if (clr_buffer !== 1'b1) begin n_fail++; $display("FAIL single_clr_hi: got %b expected 1", clr_buffer); end
    @(negedge clk);
    n_checks++; if (clr_buffer !== 1'b0) begin n_fail++; $display("FAIL single_clr_lo: got %b expected 0", clr_buffer); end
    repeat (4) @(negedge clk);
    n_checks++; if (count !== 5'd1 || clr_buffer !== 1'b0) begin n_fail++; $display("FAIL single_held_low: got count %0d clr %b expected 1 0", count, clr_buffer); end
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL single_pop: got empty %b count %0d expected 1 0", empty, count); end
  endtask

  task automatic test_fill_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 2, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin n_fail++; $display("FAIL fill_full: got full %b count %0d ovr %b expected 1 16 0", full, count, overrun); end
    send_frame(8'hFF, 2, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL ovr_count: got full %b count %0d expected 1 16", full, count); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL fill_pop_data[%0d]: got %h expected %h", i, dout, 8'(i)); end
      rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
    end
    n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL fill_drained: got empty %b count %0d expected 1 0", empty, count); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'h10 + 8'(i), 1, 1'b0, 1'b0);
    send_frame(8'hEE, 2, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd16 || overrun !== 1'b0) begin n_fail++; $display("FAIL fullpp_state: got count %0d ovr %b expected 16 0", count, overrun); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'hEE : 8'h11 + 8'(i);
      n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL fullpp_data[%0d]: got %h expected %h", i, dout, exp); end
      rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), 2, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 3", count); end
    @(negedge clk); rx_busy = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; rx_busy = 1'b0; rx_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (clr_buffer !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0) begin
        n_fail++; $display("FAIL mid_discard[%0d]: got clr %b count %0d empty %b ovr %b expected 0 0 1 0", i, clr_buffer, count, empty, overrun);
      end
      @(negedge clk);
    end
    send_frame(8'h5A, 3, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd1 || dout !== 8'h5A) begin n_fail++; $display("FAIL mid_next: got count %0d dout %h expected 1 5a", count, dout); end
  endtask

  task automatic test_random_interleave();
    logic [7:0] q[$];
    logic [7:0] b;
    logic       pop;
    int         writes = 0;
    int         iter = 0;
    do_reset();
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rd_empty: got count %0d empty %b expected 0 1", count, empty); end
    while ((writes < 40 || q.size() > 0) && iter < 2000) begin
      iter++;
      if (writes < 40 && q.size() < 16 && $urandom_range(0, 2) != 0) begin
        b = 8'($urandom);
        pop = (q.size() > 0) && ($urandom_range(0, 1) == 1);
        if (pop) begin
          n_checks++; if (dout !== q[0]) begin n_fail++; $display("FAIL rand_pushpop_data: got %h expected %h", dout, q[0]); end
          void'(q.pop_front());
        end
        send_frame(b, $urandom_range(1, 4), pop, 1'b0);
        q.push_back(b);
        writes++;
      end else if (q.size() > 0) begin
        n_checks++; if (dout !== q[0]) begin n_fail++; $display("FAIL rand_pop_data: got %h expected %h", dout, q[0]); end
        void'(q.pop_front());
        rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
      end
      n_checks++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", count, q.size()); end
    end
    n_checks++; if (writes != 40 || empty !== 1'b1) begin n_fail++; $display("FAIL rand_done: got writes %0d empty %b expected 40 1", writes, empty); end
  endtask

  task automatic test_overrun_clear();
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1, 1'b0, 1'b0);
    send_frame(8'hFF, 1, 1'b0, 1'b0);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL oc_set: got %b expected 1", overrun); end
    send_frame(8'h77, 1, 1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b1 || count !== 5'd16 || dout !== 8'h40) begin n_fail++; $display("FAIL oc_set_wins: got ovr %b count %0d dout %h expected 1 16 40", overrun, count, dout); end
    ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL oc_clear: got %b expected 0", overrun); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL oc_count: got %0d expected 16", count); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    test_random_interleave();
    test_overrun_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of byte entries in the receive FIFO; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_busy  input  1  receiver busy flag; a 1->0 transition marks a completed frame.
REQ-006 SHALL have port rx_data  input  8  received byte, valid while rx_busy=0 after a frame completes.
REQ-007 SHALL have port clr_buffer  output  1  one-cycle pulse to the receiver to clear its frame register.
REQ-008 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-009 SHALL have port dout  output  8  head-of-FIFO byte (show-ahead), valid while empty=0.
REQ-010 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port count  output  ADDR_W+1  current number of entries, 0..DEPTH.
REQ-013 SHALL have port overrun  output  1  sticky flag: a completed byte was dropped because the FIFO was full.
REQ-014 SHALL have port ovr_clr  input  1  clears overrun.

Function
REQ-015 SHALL implement a capture FSM with states IDLE, BUSY and CLEAR.
REQ-016 IDLE SHALL go to BUSY when rx_busy=1 and otherwise stay in IDLE.
REQ-017 BUSY SHALL stay while rx_busy=1; when BUSY samples rx_busy=0, it SHALL push rx_data in that same cycle and go to CLEAR.
REQ-018 CLEAR SHALL assert clr_buffer for exactly one cycle and then go to IDLE; rx_busy is ignored in CLEAR.
REQ-019 clr_buffer SHALL be registered and SHALL be high only while the FSM is in CLEAR.
REQ-020 Latency SHALL be as follows: if rx_busy=0 is sampled in BUSY at edge N, then at N+1 count has incremented, the byte is visible on dout (if the FIFO was empty) and clr_buffer=1; at N+2 clr_buffer=0.
REQ-021 A push while full=1 SHALL leave the FIFO contents, pointers and count unchanged and SHALL set overrun=1.
REQ-022 A pop (rd_en=1 with empty=0) SHALL advance the read pointer and decrement count on the next edge.
REQ-023 rd_en while empty=1 SHALL be ignored, with no state change.
REQ-024 A simultaneous push and pop while full=1 SHALL perform both, keep count=DEPTH and leave overrun unchanged.
REQ-025 A simultaneous push and pop while empty=1 SHALL perform only the push, giving count=1.
REQ-026 Simultaneous push and pop in any other state SHALL perform both and leave count unchanged.
REQ-027 Pointers SHALL be ADDR_W bits wide and wrap modulo DEPTH; empty SHALL be (count==0) and full SHALL be (count==DEPTH).
REQ-028 dout SHALL equal the storage entry at the read pointer and SHALL change only after a pop or after a push into an empty FIFO.
REQ-029 overrun SHALL stay at 1 until ovr_clr=1; if ovr_clr and a new overrun occur in the same cycle, the overrun set SHALL win.
REQ-030 Only the 1->0 edge seen by the FSM SHALL produce a push; a held rx_busy=0 SHALL produce no further pushes.

Reset
REQ-031 With reset=1 at a clock edge, the FSM SHALL go to IDLE and pointers, count, overrun and clr_buffer SHALL go to 0, making empty=1 and full=0.
REQ-032 Reset SHALL take priority over push, pop and ovr_clr in the same cycle.
REQ-033 Storage contents SHALL not be reset; dout is don't-care while empty=1.
REQ-034 Reset asserted mid-frame (BUSY) SHALL discard the frame with no push and no clr_buffer pulse.
REQ-035 If rx_busy=1 when reset is released, the FSM SHALL enter BUSY one cycle later and capture normally.

Verification
REQ-036 Pulse rx_busy high for 10 cycles, then low with rx_data=8'hA5 -> one cycle later count=1, empty=0, dout=8'hA5, clr_buffer=1 for exactly one cycle.
REQ-037 Deliver 16 frames 8'h00..8'h0F, then a 17th frame 8'hFF -> full=1, count=16, overrun=1; then pop 16 times -> dout sequence 00..0F, then empty=1.
REQ-038 FIFO full, rx_busy falling and rd_en=1 in the same cycle -> count stays 16, overrun stays 0, and the new byte becomes the last entry read.
REQ-039 Assert reset while in BUSY with 3 bytes stored -> count=0, empty=1, overrun=0, no clr_buffer pulse; the next frame is captured normally.
REQ-040 rd_en=1 while empty -> no change; write and read 40 bytes with random interleaving -> pointer wrap is exercised and data order is preserved.
REQ-041 overrun=1 with ovr_clr=1 and a new overflow in the same cycle -> overrun stays 1; ovr_clr=1 alone -> overrun=0 on the next edge.
